demux_route: RTL and testbench

- Registered 1-to-N demultiplexer: the write-side counterpart of the binary-tree mux.
- Accepts one DATA_SZ word per cycle with a lane select and delivers it to one of N = 2^(LEVEL-1) output lanes.
- Each lane has a one-entry holding register and its own valid/ready handshake.
- Output lanes are packed flat, lane i at bits [i*DATA_SZ +: DATA_SZ], matching the mux raw-bus layout so the two blocks chain back to back.

---
 rtl/demux_route.sv | 111 +++++++++++
 tb/tb_demux_route.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_route.sv
`default_nettype none
// ============================================================================
//  Module      : demux_route
//  Description : Registered 1-to-N demultiplexer. Routes one DATA_SZ word per
//                cycle to one of N = 2^(LEVEL-1) lanes. Each lane has a
//                one-entry holding register with its own valid/ready
//                handshake. Out-of-range selects are sunk and counted.
//                Lane i is packed at out_data[i*DATA_SZ +: DATA_SZ].
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_route #(
   parameter int LEVEL   = 4,
   parameter int DATA_SZ = 4,
   parameter int SEL_SZ  = 3,
   parameter int ERR_SZ  = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_SZ-1:0]                  in_data,
   input  logic [SEL_SZ-1:0]                   in_sel,
   output logic [(1<<(LEVEL-1))-1:0]           out_valid,
   input  logic [(1<<(LEVEL-1))-1:0]           out_ready,
   output logic [(1<<(LEVEL-1))*DATA_SZ-1:0]   out_data,
   output logic                                err_pulse,
   output logic [ERR_SZ-1:0]                   err_cnt
);

   localparam int c_lanes = 1 << (LEVEL - 1);
   localparam int c_idx_w = LEVEL - 1;
   // Comparison width wide enough to hold both the select and the lane count,
   // so the range test never truncates (sel == N must not alias lane 0).
   localparam int c_cmp_w = ((SEL_SZ > LEVEL) ? SEL_SZ : LEVEL) + 1;
   localparam logic [c_cmp_w-1:0] c_lanes_ext = c_cmp_w'(c_lanes);
   localparam logic [ERR_SZ-1:0]  c_err_max   = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } lane_state_t;

   logic [c_cmp_w-1:0] w_sel_ext;
   logic               w_in_range;
   logic [c_idx_w-1:0] w_lane;
   logic               w_fire;
   logic               w_drop;
   logic               r_err_pulse;
   logic [ERR_SZ-1:0]  r_err_cnt;

   assign w_sel_ext  = {{(c_cmp_w-SEL_SZ){1'b0}}, in_sel};
   assign w_in_range = (w_sel_ext < c_lanes_ext);
   assign w_lane     = in_sel[c_idx_w-1:0];

   // Accept when the target lane is empty or draining this cycle; sink out-of-range words.
   always_comb begin
      in_ready = 1'b1;
      if (w_in_range) begin
         in_ready = !out_valid[w_lane] | out_ready[w_lane];
      end
   end

   assign w_fire = in_valid & in_ready;
   assign w_drop = w_fire & ~w_in_range;

   generate
      for (genvar i = 0; i < c_lanes; i++) begin : g_lane
         lane_state_t        r_state;
         logic [DATA_SZ-1:0] r_data;
         logic               w_hit;
         logic               w_drain;

         assign w_hit   = w_fire & w_in_range & (w_lane == c_idx_w'(i));
         assign w_drain = (r_state == FULL) & out_ready[i];

         // Lane holding register: a hit fills or refills, a drain without hit empties.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_state <= EMPTY;
               r_data  <= '0;
            end else if (w_hit) begin
               r_state <= FULL;
               r_data  <= in_data;
            end else if (w_drain) begin
               r_state <= EMPTY;
            end
         end

         assign out_valid[i]                      = (r_state == FULL);
         assign out_data[i*DATA_SZ +: DATA_SZ]    = r_data;
      end
   endgenerate

   // Dropped-word pulse and saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_err_pulse <= w_drop;
         if (w_drop && (r_err_cnt != c_err_max)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
      end
   end

   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_route.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_route
//  Description : Self-checking bench for demux_route (8 lanes, 4-bit select).
//                A second instance with a 2-bit error counter shares the
//                stimulus to exercise counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_route;

   localparam int LEVEL   = 4;
   localparam int DATA_SZ = 4;
   localparam int SEL_SZ  = 4;
   localparam int ERR_SZ  = 8;
   localparam int N       = 1 << (LEVEL - 1);

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_SZ-1:0]   in_data;
   logic [SEL_SZ-1:0]    in_sel;
   logic [N-1:0]         out_valid;
   logic [N-1:0]         out_ready;
   logic [N*DATA_SZ-1:0] out_data;
   logic                 err_pulse;
   logic [ERR_SZ-1:0]    err_cnt;

   logic                 s_in_ready;
   logic [N-1:0]         s_out_valid;
   logic [N*DATA_SZ-1:0] s_out_data;
   logic                 s_err_pulse;
   logic [1:0]           s_err_cnt;

   int checks = 0;
   int errors = 0;
   logic [DATA_SZ-1:0] exp_q[$];

   demux_route #(.LEVEL(LEVEL), .DATA_SZ(DATA_SZ), .SEL_SZ(SEL_SZ), .ERR_SZ(ERR_SZ)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err_pulse(err_pulse), .err_cnt(err_cnt)
   );

   demux_route #(.LEVEL(LEVEL), .DATA_SZ(DATA_SZ), .SEL_SZ(SEL_SZ), .ERR_SZ(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_sel(in_sel),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .err_pulse(s_err_pulse), .err_cnt(s_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
      tick(); tick();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_valid got %h expected %h", out_valid, 8'h00); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h expected %h", out_data, 32'h0); end
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b expected 0", err_pulse); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d expected 0", err_cnt); end
      rst_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", in_ready); end
   endtask

   task automatic test_basic_route();
      logic [DATA_SZ-1:0] exp;
      in_sel = 4'd5; in_data = 4'hA; in_valid = 1'b1; out_ready = '0;
      exp_q.push_back(4'hA);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 8'b0010_0000) begin errors++; $display("FAIL basic_valid got %b expected %b", out_valid, 8'b0010_0000); end
      if (out_valid[5]) begin
         exp = exp_q.pop_front();
         checks++; if (out_data[23:20] !== exp) begin errors++; $display("FAIL basic_data got %h expected %h", out_data[23:20], exp); end
      end
      out_ready = 8'h20;
      tick();
      out_ready = '0;
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL basic_drain got %b expected 0", out_valid); end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      in_sel = 4'd3; in_data = 4'h3; in_valid = 1'b1; out_ready = '0;
      tick();
      in_data = 4'hC;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked got %b expected 0", in_ready); end
      tick();
      checks++; if (out_valid[3] !== 1'b1 || out_data[15:12] !== 4'h3) begin errors++; $display("FAIL bp_stable got v=%b d=%h expected v=1 d=3", out_valid[3], out_data[15:12]); end
      out_ready[3] = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0; out_ready = '0;
      checks++; if (out_valid[3] !== 1'b1 || out_data[15:12] !== 4'hC) begin errors++; $display("FAIL bp_refill got v=%b d=%h expected v=1 d=c", out_valid[3], out_data[15:12]); end
   endtask

   task automatic test_nonblocking();
      out_ready = '0;
      for (int k = 0; k < 3; k++) begin
         in_sel = SEL_SZ'(k); in_data = DATA_SZ'(k + 1); in_valid = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nb_ready_%0d got %b expected 1", k, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 8'b0000_1111) begin errors++; $display("FAIL nb_valid got %b expected %b", out_valid, 8'b0000_1111); end
      checks++; if (out_data[15:0] !== 16'hC321) begin errors++; $display("FAIL nb_data got %h expected %h", out_data[15:0], 16'hC321); end
      out_ready = 8'hFF;
      tick();
      out_ready = '0;
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL nb_drain got %b expected 0", out_valid); end
   endtask

   task automatic test_out_of_range();
      in_sel = 4'd9; in_data = 4'h7; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL oor_ready_%0d got %b expected 1", k, in_ready); end
         tick();
         checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL oor_pulse_%0d got %b expected 1", k, err_pulse); end
      end
      in_valid = 1'b0;
      checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL oor_cnt got %0d expected 3", err_cnt); end
      checks++; if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL oor_sat_cnt3 got %0d expected 3", s_err_cnt); end
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL oor_lanes got %b expected 0", out_valid); end
      tick();
      checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL oor_pulse_end got %b expected 0", err_pulse); end
      // sel == N must not alias lane 0
      in_sel = 4'd8; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL oor_alias got %b expected 0", out_valid); end
      checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL oor_cnt5 got %0d expected 5", err_cnt); end
      checks++; if (s_err_cnt !== 2'd3) begin errors++; $display("FAIL oor_saturate got %0d expected 3", s_err_cnt); end
   endtask

   task automatic test_throughput();
      logic [DATA_SZ-1:0] exp;
      int got;
      got = 0;
      in_sel = 4'd7; out_ready = 8'h80; in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_data = DATA_SZ'(k);
         exp_q.push_back(DATA_SZ'(k));
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tp_ready_%0d got %b expected 1", k, in_ready); end
         tick();
         if (out_valid[7] === 1'b1 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got++;
            checks++; if (out_data[31:28] !== exp) begin errors++; $display("FAIL tp_data_%0d got %h expected %h", k, out_data[31:28], exp); end
         end
      end
      in_valid = 1'b0;
      checks++; if (got !== 16) begin errors++; $display("FAIL tp_count got %0d expected 16", got); end
      tick();
      out_ready = '0;
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL tp_drain got %b expected 0", out_valid); end
      exp_q.delete();
   endtask

   task automatic test_async_reset();
      out_ready = '0;
      in_sel = 4'd1; in_data = 4'h5; in_valid = 1'b1;
      tick();
      in_sel = 4'd6; in_data = 4'h9;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 8'b0100_0010) begin errors++; $display("FAIL ar_fill got %b expected %b", out_valid, 8'b0100_0010); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL ar_valid got %b expected 0", out_valid); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL ar_cnt got %0d expected 0", err_cnt); end
      #2 rst_n = 1'b1;
      tick();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL ar_stale got %b expected 0", out_valid); end
      in_sel = 4'd2; in_data = 4'h7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 8'b0000_0100 || out_data[11:8] !== 4'h7) begin errors++; $display("FAIL ar_after got v=%b d=%h expected v=00000100 d=7", out_valid, out_data[11:8]); end
   endtask

   initial begin
      test_reset();
      test_basic_route();
      test_backpressure();
      test_nonblocking();
      test_out_of_range();
      test_throughput();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
